// File: rtl/jtag_uart_rx_bridge.sv
// jtag_uart_rx_bridge
//
// Receive-side bridge between the JTAG UART core and the solver's serial
// input. It acts as an Avalon-MM master that polls the JTAG UART data
// register and pushes every valid received byte into a small FIFO. The
// FIFO is presented to the solver as a valid/ready byte stream.
//
// Ports:
//   clock, reset        system clock; synchronous active-high reset
//   jtag_address        Avalon address, tied to the data register (0)
//   jtag_read           Avalon read request, held until the slave completes
//   jtag_write          tied low, this bridge never writes
//   jtag_writedata      tied to zero
//   jtag_waitrequest    Avalon wait; a read completes when it is low
//   jtag_readdata       [7:0] byte, [15] RVALID, [31:16] RAVAIL
//   rx_valid            FIFO holds at least one byte
//   rx_data             FIFO head byte
//   rx_ready            consumer accepts the head byte this cycle
//   rx_count            FIFO occupancy, 0 to DEPTH
module jtag_uart_rx_bridge #(
    parameter int DEPTH      = 16,
    parameter int LOG2_DEPTH = 4,
    parameter int POLL_GAP   = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [2:0]            jtag_address,
    output logic                  jtag_read,
    output logic                  jtag_write,
    output logic [31:0]           jtag_writedata,
    input  logic                  jtag_waitrequest,
    input  logic [31:0]           jtag_readdata,
    output logic                  rx_valid,
    output logic [7:0]            rx_data,
    input  logic                  rx_ready,
    output logic [LOG2_DEPTH:0]   rx_count
);

    localparam logic [LOG2_DEPTH:0] FULL_COUNT = (LOG2_DEPTH + 1)'(DEPTH);
    localparam logic [7:0]          GAP_RELOAD = 8'(POLL_GAP);

    typedef enum logic {
        S_IDLE,
        S_READ
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              gap_q, gap_d;
    logic [LOG2_DEPTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LOG2_DEPTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LOG2_DEPTH:0]     count_q, count_d;
    logic [7:0]              mem_q [DEPTH];

    logic                    push;
    logic                    pop;
    logic                    byte_valid;
    logic                    more_bytes;
    logic                    unused_readdata_bits;

    assign byte_valid = jtag_readdata[15];
    assign more_bytes = |jtag_readdata[31:16];

    // Bits [14:8] of the data register carry nothing this bridge needs.
    assign unused_readdata_bits = ^jtag_readdata[14:8];

    assign jtag_address   = 3'd0;
    assign jtag_write     = 1'b0;
    assign jtag_writedata = 32'd0;
    assign jtag_read      = (state_q == S_READ);

    assign rx_valid = (count_q != '0);
    assign rx_data  = mem_q[rd_ptr_q];
    assign rx_count = count_q;

    // Next-state logic for the poll FSM, gap counter and FIFO bookkeeping.
    // A read is only launched with room in the FIFO, and only one read is
    // ever outstanding, so a push can never find the FIFO full.
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        push     = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        case (state_q)
            S_IDLE: begin
                if (gap_q != 8'd0) begin
                    gap_d = gap_q - 8'd1;
                end else if (count_q < FULL_COUNT) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                // Reads are destructive in the slave, so the request stays
                // up until the slave completes it.
                if (!jtag_waitrequest) begin
                    push    = byte_valid;
                    gap_d   = (byte_valid && more_bytes) ? 8'd0 : GAP_RELOAD;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        pop = rx_valid && rx_ready;

        if (push) begin
            wr_ptr_d = wr_ptr_q + LOG2_DEPTH'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + LOG2_DEPTH'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + (LOG2_DEPTH + 1)'(1);
            2'b01:   count_d = count_q - (LOG2_DEPTH + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // All control state lives in one register block.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            gap_q    <= 8'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Byte storage is left unreset; the count alone says what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= jtag_readdata[7:0];
        end
    end

endmodule

// File: tb/tb_jtag_uart_rx_bridge.sv
// tb_jtag_uart_rx_bridge
//
// Directed bench for jtag_uart_rx_bridge. The bench plays the JTAG UART
// slave cycle by cycle: inputs change on the falling edge, outputs are
// sampled on the falling edge, and a free-running cycle counter timestamps
// read starts and completions.
module tb_jtag_uart_rx_bridge;

    localparam int DEPTH      = 16;
    localparam int LOG2_DEPTH = 4;
    localparam int POLL_GAP   = 15;

    logic                  clock;
    logic                  reset;
    logic [2:0]            jtag_address;
    logic                  jtag_read;
    logic                  jtag_write;
    logic [31:0]           jtag_writedata;
    logic                  jtag_waitrequest;
    logic [31:0]           jtag_readdata;
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rx_ready;
    logic [LOG2_DEPTH:0]   rx_count;

    int tests;
    int fails;
    int cyc;

    jtag_uart_rx_bridge #(
        .DEPTH      (DEPTH),
        .LOG2_DEPTH (LOG2_DEPTH),
        .POLL_GAP   (POLL_GAP)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .jtag_address     (jtag_address),
        .jtag_read        (jtag_read),
        .jtag_write       (jtag_write),
        .jtag_writedata   (jtag_writedata),
        .jtag_waitrequest (jtag_waitrequest),
        .jtag_readdata    (jtag_readdata),
        .rx_valid         (rx_valid),
        .rx_data          (rx_data),
        .rx_ready         (rx_ready),
        .rx_count         (rx_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Wait for a read request, hold waitrequest for 'waits' cycles, then
    // complete it with 'data'. Returns on the falling edge after completion.
    task automatic serve_read(input int waits, input logic [31:0] data,
                              input bit pop_at_done, output int start_cyc,
                              output int done_cyc, output int held);
        int n;
        n = 0;
        held = 0;
        start_cyc = -1;
        done_cyc = -1;
        while (jtag_read !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (jtag_read !== 1'b1) begin
            tests++;
            fails++;
            $display("[TB] FAIL read_timeout: jtag_read=%b after %0d cycles, required 1", jtag_read, n);
            return;
        end
        start_cyc = cyc;
        held = 1;
        if (waits > 0) jtag_waitrequest = 1'b1;
        repeat (waits) begin
            @(negedge clock);
            if (jtag_read === 1'b1) held++;
        end
        jtag_waitrequest = 1'b0;
        jtag_readdata = data;
        if (pop_at_done) rx_ready = 1'b1;
        done_cyc = cyc;
        @(negedge clock);
        jtag_readdata = 32'd0;
        if (pop_at_done) rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        tests++;
        if (jtag_read !== 1'b0 || rx_valid !== 1'b0 || rx_count !== 5'd0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: read=%b valid=%b count=%0d, required 0 0 0", jtag_read, rx_valid, rx_count);
        end
        tests++;
        if (jtag_address !== 3'd0 || jtag_write !== 1'b0 || jtag_writedata !== 32'd0) begin
            fails++;
            $display("[TB] FAIL tied_outputs: addr=%0d write=%b wdata=%h, required 0 0 0", jtag_address, jtag_write, jtag_writedata);
        end
        reset = 1'b0;
        tests++;
        if (jtag_read !== 1'b0) begin
            fails++;
            $display("[TB] FAIL first_cycle_idle: jtag_read=%b, required 0", jtag_read);
        end
        @(negedge clock);
        tests++;
        if (jtag_read !== 1'b1) begin
            fails++;
            $display("[TB] FAIL first_read: jtag_read=%b, required 1", jtag_read);
        end
    endtask

    task automatic test_single_byte();
        int s, d, h, s2, d2, h2;
        serve_read(0, 32'h0000_8041, 1'b0, s, d, h);
        tests++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h41 || rx_count !== 5'd1) begin
            fails++;
            $display("[TB] FAIL single_push: valid=%b data=%h count=%0d, required 1 41 1", rx_valid, rx_data, rx_count);
        end
        tests++;
        if (jtag_read !== 1'b0) begin
            fails++;
            $display("[TB] FAIL single_idle_after: jtag_read=%b, required 0", jtag_read);
        end
        serve_read(0, 32'd0, 1'b0, s2, d2, h2);
        tests++;
        if (s2 != d + POLL_GAP + 2) begin
            fails++;
            $display("[TB] FAIL single_poll_gap: next read at +%0d, required +%0d", s2 - d, POLL_GAP + 2);
        end
        rx_ready = 1'b1;
        @(negedge clock);
        rx_ready = 1'b0;
        tests++;
        if (rx_valid !== 1'b0 || rx_count !== 5'd0) begin
            fails++;
            $display("[TB] FAIL single_pop: valid=%b count=%0d, required 0 0", rx_valid, rx_count);
        end
    endtask

    task automatic test_wait_states();
        int s, d, h, s2, d2, h2;
        serve_read(3, 32'h0002_8055, 1'b0, s, d, h);
        tests++;
        if (h != 4 || d - s != 3) begin
            fails++;
            $display("[TB] FAIL wait_held: held=%0d span=%0d, required 4 3", h, d - s);
        end
        tests++;
        if (rx_count !== 5'd1 || rx_data !== 8'h55 || jtag_read !== 1'b0) begin
            fails++;
            $display("[TB] FAIL wait_push: count=%0d data=%h read=%b, required 1 55 0", rx_count, rx_data, jtag_read);
        end
        serve_read(0, 32'd0, 1'b0, s2, d2, h2);
        tests++;
        if (s2 != d + 2) begin
            fails++;
            $display("[TB] FAIL wait_burst_gap: next read at +%0d, required +2", s2 - d);
        end
        tests++;
        if (rx_count !== 5'd1) begin
            fails++;
            $display("[TB] FAIL wait_single_push: count=%0d, required 1", rx_count);
        end
        rx_ready = 1'b1;
        @(negedge clock);
        rx_ready = 1'b0;
    endtask

    task automatic test_empty_polling();
        int s0, s1, s2, d, h0, h1, h2;
        serve_read(0, 32'd0, 1'b0, s0, d, h0);
        serve_read(0, 32'd0, 1'b0, s1, d, h1);
        serve_read(0, 32'd0, 1'b0, s2, d, h2);
        tests++;
        if (s1 - s0 != POLL_GAP + 2 || s2 - s1 != POLL_GAP + 2) begin
            fails++;
            $display("[TB] FAIL empty_spacing: spacing %0d %0d, required %0d", s1 - s0, s2 - s1, POLL_GAP + 2);
        end
        tests++;
        if (h0 != 1 || h1 != 1 || h2 != 1 || jtag_read !== 1'b0) begin
            fails++;
            $display("[TB] FAIL empty_pulse_width: held %0d %0d %0d read=%b, required 1 1 1 0", h0, h1, h2, jtag_read);
        end
        tests++;
        if (rx_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL empty_valid: rx_valid=%b, required 0", rx_valid);
        end
    endtask

    task automatic test_backpressure();
        int s, d, h, prev_d, reads_while_full;
        logic [7:0] got [$];
        prev_d = -100;
        rx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            serve_read(0, {16'd1, 8'h80, 8'(i)}, 1'b0, s, d, h);
            if (i > 0) begin
                tests++;
                if (s != prev_d + 2) begin
                    fails++;
                    $display("[TB] FAIL bp_burst_gap: byte %0d read at +%0d, required +2", i, s - prev_d);
                end
            end
            prev_d = d;
        end
        tests++;
        if (rx_count !== 5'd16) begin
            fails++;
            $display("[TB] FAIL bp_full_count: count=%0d, required 16", rx_count);
        end
        reads_while_full = 0;
        repeat (30) begin
            @(negedge clock);
            if (jtag_read !== 1'b0) reads_while_full++;
        end
        tests++;
        if (reads_while_full != 0 || rx_count !== 5'd16) begin
            fails++;
            $display("[TB] FAIL bp_quiet_full: read cycles=%0d count=%0d, required 0 16", reads_while_full, rx_count);
        end
        rx_ready = 1'b1;
        fork
            begin
                int bs, bd, bh;
                for (int i = 16; i < 20; i++) begin
                    serve_read(0, {16'd1, 8'h80, 8'(i)}, 1'b0, bs, bd, bh);
                end
            end
            begin
                for (int n = 0; n < 300; n++) begin
                    if (rx_valid === 1'b1) got.push_back(rx_data);
                    if (got.size() >= 20) break;
                    @(negedge clock);
                end
            end
        join
        @(negedge clock);
        rx_ready = 1'b0;
        tests++;
        if (got.size() != 20) begin
            fails++;
            $display("[TB] FAIL bp_drain_count: drained %0d bytes, required 20", got.size());
        end
        for (int i = 0; i < got.size() && i < 20; i++) begin
            tests++;
            if (got[i] !== 8'(i)) begin
                fails++;
                $display("[TB] FAIL bp_drain_order: byte %0d=%h, required %h", i, got[i], 8'(i));
            end
        end
        tests++;
        if (rx_valid !== 1'b0 || rx_count !== 5'd0) begin
            fails++;
            $display("[TB] FAIL bp_empty_after: valid=%b count=%0d, required 0 0", rx_valid, rx_count);
        end
    endtask

    task automatic test_simultaneous();
        int s, d, h;
        logic [7:0] b;
        serve_read(0, 32'h0001_8077, 1'b0, s, d, h);
        tests++;
        if (rx_count !== 5'd1 || rx_data !== 8'h77) begin
            fails++;
            $display("[TB] FAIL sim_setup: count=%0d data=%h, required 1 77", rx_count, rx_data);
        end
        serve_read(0, 32'h0001_8099, 1'b1, s, d, h);
        tests++;
        if (rx_count !== 5'd1 || rx_data !== 8'h99) begin
            fails++;
            $display("[TB] FAIL sim_push_pop: count=%0d data=%h, required 1 99", rx_count, rx_data);
        end
        for (int i = 0; i < 40; i++) begin
            b = 8'hA0 + 8'(i);
            serve_read(0, {16'd1, 8'h80, b}, 1'b1, s, d, h);
            tests++;
            if (rx_data !== b || rx_count !== 5'd1) begin
                fails++;
                $display("[TB] FAIL sim_wrap: step %0d data=%h count=%0d, required %h 1", i, rx_data, rx_count, b);
            end
        end
        rx_ready = 1'b1;
        @(negedge clock);
        rx_ready = 1'b0;
        tests++;
        if (rx_count !== 5'd0) begin
            fails++;
            $display("[TB] FAIL sim_final_pop: count=%0d, required 0", rx_count);
        end
    endtask

    task automatic test_reset_mid();
        int s, d, h, n;
        for (int i = 0; i < 3; i++) begin
            serve_read(0, {16'd1, 8'h80, 8'(8'h30 + i)}, 1'b0, s, d, h);
        end
        tests++;
        if (rx_count !== 5'd3) begin
            fails++;
            $display("[TB] FAIL rm_buffered: count=%0d, required 3", rx_count);
        end
        n = 0;
        while (jtag_read !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        tests++;
        if (jtag_read !== 1'b1) begin
            fails++;
            $display("[TB] FAIL rm_read_seen: jtag_read=%b, required 1", jtag_read);
        end
        jtag_waitrequest = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        tests++;
        if (jtag_read !== 1'b0 || rx_valid !== 1'b0 || rx_count !== 5'd0) begin
            fails++;
            $display("[TB] FAIL rm_reset_state: read=%b valid=%b count=%0d, required 0 0 0", jtag_read, rx_valid, rx_count);
        end
        @(negedge clock);
        reset = 1'b0;
        jtag_waitrequest = 1'b0;
        @(negedge clock);
        tests++;
        if (jtag_read !== 1'b1) begin
            fails++;
            $display("[TB] FAIL rm_resume: jtag_read=%b, required 1", jtag_read);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        jtag_waitrequest = 1'b0;
        jtag_readdata = 32'd0;
        rx_ready = 1'b0;
        test_reset();
        test_single_byte();
        test_wait_states();
        test_empty_polling();
        test_backpressure();
        test_simultaneous();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
